// File: rtl/crc_block_sequencer.sv
// Block CRC-8 sequencer (poly 0x85): serialises bytes MSB-first,
// appends 8 zero flush bits and strobes done with the final CRC.
module crc_block_sequencer #(
   parameter int unsigned BLOCK_BYTES = 32,
   parameter logic [7:0]  SEED        = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       busy,
   output logic       done,
   output logic [7:0] crc
);

   localparam int unsigned CW = $clog2(BLOCK_BYTES + 1);
   localparam logic [CW-1:0] LAST = CW'(BLOCK_BYTES);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      FLUSH,
      DONE
   } state_t;

   state_t        state, state_nx;
   logic [7:0]    crc_q, crc_nx;
   logic [7:0]    sreg, sreg_nx;
   logic [CW-1:0] byte_cnt, byte_cnt_nx, byte_inc;
   logic [2:0]    bit_cnt, bit_cnt_nx;
   logic          ready_c;

   function automatic logic [7:0] crc_step(
      input logic [7:0] w,
      input logic       d
   );
      return {w[6] ^ w[7], w[5:2], w[1] ^ w[7], w[0], d ^ w[7]};
   endfunction

   assign byte_inc = byte_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         crc_q    <= SEED;
         sreg     <= 8'h00;
         byte_cnt <= '0;
         bit_cnt  <= 3'd0;
      end else begin
         state    <= state_nx;
         crc_q    <= crc_nx;
         sreg     <= sreg_nx;
         byte_cnt <= byte_cnt_nx;
         bit_cnt  <= bit_cnt_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      crc_nx      = crc_q;
      sreg_nx     = sreg;
      byte_cnt_nx = byte_cnt;
      bit_cnt_nx  = bit_cnt;
      ready_c     = 1'b0;
      // abort outranks everything except reset, including the handshake
      if (abort && state != IDLE) begin
         state_nx    = IDLE;
         crc_nx      = SEED;
         byte_cnt_nx = '0;
         bit_cnt_nx  = 3'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start && !abort) begin
                  state_nx    = LOAD;
                  crc_nx      = SEED;
                  byte_cnt_nx = '0;
                  bit_cnt_nx  = 3'd0;
               end
            end
            LOAD: begin
               ready_c = 1'b1;
               if (in_valid) begin
                  sreg_nx    = in_data;
                  bit_cnt_nx = 3'd0;
                  state_nx   = SHIFT;
               end
            end
            SHIFT: begin
               crc_nx     = crc_step(crc_q, sreg[7]);
               sreg_nx    = {sreg[6:0], 1'b0};
               bit_cnt_nx = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  byte_cnt_nx = byte_inc;
                  state_nx    = (byte_inc == LAST) ? FLUSH : LOAD;
               end
            end
            FLUSH: begin
               crc_nx     = crc_step(crc_q, 1'b0);
               bit_cnt_nx = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  state_nx = DONE;
               end
            end
            DONE: begin
               state_nx = IDLE;
            end
            default: begin
               state_nx = IDLE;
            end
         endcase
      end
   end

   assign in_ready = ready_c && !reset;
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
   assign crc      = crc_q;

endmodule

// File: tb/tb_crc_block_sequencer.sv
// Bench for crc_block_sequencer: table of single-byte blocks plus
// hand sequences for stalls, abort, stray start and reset mid-flush.
module tb_crc_block_sequencer;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [7:0]       in_data = 8'h00;
   logic             in_valid = 1'b0;
   logic [2:0]       start = 3'b000;
   logic [2:0]       abort = 3'b000;
   logic [2:0]       in_ready, busy, done;
   logic [2:0][7:0]  crc_v;

   int               passed = 0;
   int               total = 0;
   int               edges = 0;
   int               done_cnt [3] = '{0, 0, 0};
   int               rdy_cnt [3] = '{0, 0, 0};
   logic [7:0]       blk [64];
   logic [7:0]       exp_q [$];

   typedef struct {
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [5];

   always #5 clk = ~clk;

   crc_block_sequencer #(.BLOCK_BYTES(1), .SEED(8'h00)) u_b1 (
      .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[0]),
      .busy(busy[0]), .done(done[0]), .crc(crc_v[0])
   );

   crc_block_sequencer #(.BLOCK_BYTES(2), .SEED(8'h00)) u_b2 (
      .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[1]),
      .busy(busy[1]), .done(done[1]), .crc(crc_v[1])
   );

   crc_block_sequencer #(.BLOCK_BYTES(32), .SEED(8'h00)) u_b32 (
      .clk(clk), .reset(reset), .start(start[2]), .abort(abort[2]),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[2]),
      .busy(busy[2]), .done(done[2]), .crc(crc_v[2])
   );

   always @(negedge clk) begin
      for (int s = 0; s < 3; s++) begin
         if (done[s]) done_cnt[s]++;
         if (in_ready[s]) rdy_cnt[s]++;
      end
   end

   // Polynomial division reference: augmented message, MSB first
   function automatic logic [7:0] model_crc(input int n);
      logic [7:0] c;
      logic       d;
      c = 8'h00;
      for (int b = 0; b < n + 1; b++) begin
         for (int i = 7; i >= 0; i--) begin
            d = (b < n) ? blk[b][i] : 1'b0;
            c = {c[6:0], d} ^ (c[7] ? 8'h85 : 8'h00);
         end
      end
      return c;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edges++;
   endtask

   task automatic wait_ready(input int s);
      int g = 0;
      while (!in_ready[s] && g < 30) begin
         tick();
         g++;
      end
      if (!in_ready[s]) check("ready_timeout", 0, 1);
   endtask

   task automatic feed_byte(input int s, input logic [7:0] d);
      wait_ready(s);
      in_data  = d;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic run_block(input int s, input int n, input logic [7:0] exp,
                            input int stall_at, input int stall_len,
                            input int stray_at);
      int         d0, r0, g;
      logic [7:0] hold, got, want;
      exp_q.push_back(exp);
      d0 = done_cnt[s];
      r0 = rdy_cnt[s];
      start[s] = 1'b1;
      tick();
      start[s] = 1'b0;
      edges = 0;
      check("start_busy", busy[s], 1);
      for (int b = 0; b < n; b++) begin
         if (b == stall_at) begin
            wait_ready(s);
            hold = crc_v[s];
            repeat (stall_len) begin
               check("stall_ready", in_ready[s], 1);
               tick();
            end
            check("stall_crc", crc_v[s], hold);
         end
         feed_byte(s, blk[b]);
         if (b == stray_at) begin
            start[s] = 1'b1;
            tick();
            start[s] = 1'b0;
         end
      end
      g = 0;
      while (!done[s] && g < 40) begin
         tick();
         g++;
      end
      check("done", done[s], 1);
      check("latency", edges, 9 * n + 8 + stall_len);
      got  = crc_v[s];
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check("crc", got, want);
      tick();
      check("post_done", done[s], 0);
      check("post_busy", busy[s], 0);
      check("crc_hold", crc_v[s], got);
      check("done_pulses", done_cnt[s] - d0, 1);
      check("ready_cycles", rdy_cnt[s] - r0, n + stall_len);
   endtask

   initial begin
      int d0;
      vecs[0] = '{data: 8'h01, exp: 8'h85};
      vecs[1] = '{data: 8'h02, exp: 8'h8F};
      vecs[2] = '{data: 8'h00, exp: 8'h00};
      blk[0] = 8'hFF;
      vecs[3] = '{data: 8'hFF, exp: model_crc(1)};
      blk[0] = 8'h80;
      vecs[4] = '{data: 8'h80, exp: model_crc(1)};

      repeat (3) tick();
      reset = 1'b0;
      for (int s = 0; s < 3; s++) begin
         check("rst_busy", busy[s], 0);
         check("rst_done", done[s], 0);
         check("rst_ready", in_ready[s], 0);
         check("rst_crc", crc_v[s], 8'h00);
      end

      for (int i = 0; i < 5; i++) begin
         blk[0] = vecs[i].data;
         run_block(0, 1, vecs[i].exp, -1, 0, -1);
      end

      for (int b = 0; b < 32; b++) blk[b] = 8'h00;
      run_block(2, 32, 8'h00, -1, 0, -1);

      blk[0] = 8'h00;
      blk[1] = 8'h01;
      run_block(1, 2, 8'h85, 1, 5, -1);

      for (int b = 0; b < 32; b++) blk[b] = 8'($urandom_range(0, 255));
      run_block(2, 32, model_crc(32), -1, 0, 5);

      // abort in the 3rd shift cycle of the 10th byte
      d0 = done_cnt[2];
      start[2] = 1'b1;
      tick();
      start[2] = 1'b0;
      for (int b = 0; b < 10; b++) feed_byte(2, 8'h5A ^ 8'(b));
      tick();
      tick();
      abort[2] = 1'b1;
      tick();
      abort[2] = 1'b0;
      check("abort_busy", busy[2], 0);
      check("abort_done", done[2], 0);
      check("abort_crc", crc_v[2], 8'h00);
      repeat (20) tick();
      check("abort_no_done", done_cnt[2] - d0, 0);

      // abort in LOAD blocks the handshake
      start[1] = 1'b1;
      tick();
      start[1] = 1'b0;
      abort[1] = 1'b1;
      in_valid = 1'b1;
      #1;
      check("abort_ready", in_ready[1], 0);
      tick();
      abort[1] = 1'b0;
      in_valid = 1'b0;
      check("abort_load_busy", busy[1], 0);

      // start and abort together in IDLE
      start[0] = 1'b1;
      abort[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      abort[0] = 1'b0;
      check("abort_start_idle", busy[0], 0);

      blk[0] = 8'h01;
      run_block(0, 1, 8'h85, -1, 0, -1);

      // reset in the middle of FLUSH
      d0 = done_cnt[1];
      start[1] = 1'b1;
      tick();
      start[1] = 1'b0;
      feed_byte(1, 8'h00);
      feed_byte(1, 8'h01);
      repeat (11) tick();
      check("flush_busy", busy[1], 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_mid_busy", busy[1], 0);
      check("rst_mid_done", done[1], 0);
      check("rst_mid_ready", in_ready[1], 0);
      check("rst_mid_crc", crc_v[1], 8'h00);
      repeat (20) tick();
      check("rst_no_done", done_cnt[1] - d0, 0);

      blk[0] = 8'h02;
      run_block(0, 1, 8'h8F, -1, 0, -1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
